// File: rtl/mem_responder_if.sv
// Request/completion handshake bundle between a memory requester and mem_responder.
interface mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [32:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_op;
   logic [32:0] rsp_addr;
   logic        rsp_err;

   modport master (
      output req_valid, req_op, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_op, rsp_addr, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_op, rsp_addr, rsp_err
   );
endinterface

// File: rtl/mem_responder.sv
// In-order memory completion model: each accepted request is stamped with a due time from
// a single open-row hit/miss latency and released once the free-running counter reaches it.
module mem_responder #(
   parameter int DEPTH    = 16,
   parameter int MISS_LAT = 100,
   parameter int HIT_LAT  = 40
) (
   input  logic           clock,
   input  logic           reset,
   mem_responder_if.slave bus,
   output logic [63:0]    cycle_cnt
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [1:0]    opMem   [DEPTH];
   logic [32:0]   addrMem [DEPTH];
   logic [63:0]   dueMem  [DEPTH];

   logic [PW-1:0] headPtr;
   logic [PW-1:0] tailPtr;
   logic [CW-1:0] count;
   logic [63:0]   lastDue;
   logic [19:0]   openRow;
   logic          openRowValid;

   logic          full;
   logic          empty;
   logic          headDue;
   logic          push;
   logic          pop;
   logic          rowHit;
   logic [63:0]   latTime;
   logic [63:0]   seqTime;
   logic [63:0]   newDue;
   logic [PW-1:0] headNext;
   logic [PW-1:0] tailNext;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign headDue = !empty && (cycle_cnt >= dueMem[headPtr]);
   assign push    = bus.req_valid && !full;
   assign pop     = headDue && bus.rsp_ready;

   // Due times are forced strictly increasing so a fast hit never completes before an older miss.
   assign rowHit  = openRowValid && (openRow == bus.req_addr[32:13]);
   assign latTime = cycle_cnt + (rowHit ? 64'(HIT_LAT) : 64'(MISS_LAT));
   assign seqTime = lastDue + 64'd1;
   assign newDue  = (latTime > seqTime) ? latTime : seqTime;

   assign headNext = (headPtr == PW'(DEPTH - 1)) ? '0 : headPtr + PW'(1);
   assign tailNext = (tailPtr == PW'(DEPTH - 1)) ? '0 : tailPtr + PW'(1);

   // Outputs are forced to their idle values while reset is held, before any edge has cleared state.
   assign bus.req_ready = reset || !full;
   assign bus.rsp_valid = !reset && headDue;
   assign bus.rsp_op    = bus.rsp_valid ? opMem[headPtr] : 2'd0;
   assign bus.rsp_addr  = bus.rsp_valid ? addrMem[headPtr] : 33'd0;
   assign bus.rsp_err   = bus.rsp_valid && (opMem[headPtr] == 2'd3);

   // Entry storage needs no reset: occupancy and pointers decide what is live.
   always_ff @(posedge clock) begin
      if (push) begin
         opMem[tailPtr]   <= bus.req_op;
         addrMem[tailPtr] <= bus.req_addr;
         dueMem[tailPtr]  <= newDue;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_cnt    <= '0;
         headPtr      <= '0;
         tailPtr      <= '0;
         count        <= '0;
         lastDue      <= '0;
         openRow      <= '0;
         openRowValid <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (push) begin
            tailPtr      <= tailNext;
            lastDue      <= newDue;
            openRow      <= bus.req_addr[32:13];
            openRowValid <= 1'b1;
         end
         if (pop) begin
            headPtr <= headNext;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: stimulus pushes hand-computed completions into a scoreboard
// queue, and a negedge monitor checks timing, ordering and payload of every completion.
module tb_mem_responder;
   typedef struct {
      logic [1:0]      op;
      logic [32:0]     addr;
      logic            err;
      longint unsigned due;
   } exp_t;

   logic        clock;
   logic        reset;
   logic [63:0] cycle_cnt;

   mem_responder_if bus();

   mem_responder #(.DEPTH(16), .MISS_LAT(100), .HIT_LAT(40)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .cycle_cnt (cycle_cnt)
   );

   exp_t            sb[$];
   int              assertions = 0;
   int              failures   = 0;
   logic            headSeen   = 1'b0;
   longint unsigned lastPopCnt = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertions++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle_cnt=%0d", name, actual, expected, cycle_cnt);
      end
   endtask

   task automatic waitCnt(input longint unsigned t);
      for (int i = 0; i < 3000 && cycle_cnt != t; i++) begin
         @(posedge clock);
         #1;
      end
      checkOutput("wait for cycle_cnt", cycle_cnt, t);
   endtask

   task automatic waitValid();
      for (int i = 0; i < 300 && !bus.rsp_valid; i++) begin
         @(posedge clock);
         #1;
      end
      checkOutput("rsp_valid within bound", 64'(bus.rsp_valid), 64'd1);
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 500 && sb.size() != 0; i++) begin
         @(posedge clock);
         #1;
      end
      checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'd0;
      bus.req_addr  = 33'd0;
      bus.rsp_ready = 1'b0;
      sb.delete();
      @(posedge clock);
      #1;
      checkOutput("reset req_ready", 64'(bus.req_ready), 64'd1);
      checkOutput("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("reset rsp_op", 64'(bus.rsp_op), 64'd0);
      checkOutput("reset rsp_addr", 64'(bus.rsp_addr), 64'd0);
      checkOutput("reset rsp_err", 64'(bus.rsp_err), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      checkOutput("cycle_cnt after reset", cycle_cnt, 64'd0);
   endtask

   // Offer one request at cycle_cnt==t; the expected completion is queued before the accept edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [32:0] addr,
                                input longint unsigned t, input longint unsigned expDue);
      exp_t e;
      waitCnt(t);
      checkOutput("req_ready before accept", 64'(bus.req_ready), 64'd1);
      e.op   = op;
      e.addr = addr;
      e.err  = (op == 2'd3);
      e.due  = expDue;
      sb.push_back(e);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
   endtask

   always @(negedge clock) begin
      exp_t            e;
      longint unsigned firstDue;
      if (reset) begin
         headSeen   = 1'b0;
         lastPopCnt = 0;
         checkOutput("rsp_valid in reset", 64'(bus.rsp_valid), 64'd0);
      end else if (sb.size() == 0) begin
         checkOutput("rsp_valid with nothing pending", 64'(bus.rsp_valid), 64'd0);
      end else begin
         e = sb[0];
         firstDue = (e.due > lastPopCnt + 1) ? e.due : lastPopCnt + 1;
         if (!headSeen) begin
            if (bus.rsp_valid) begin
               headSeen = 1'b1;
               checkOutput("first rsp_valid cycle", cycle_cnt, firstDue);
               checkOutput("rsp_op", 64'(bus.rsp_op), 64'(e.op));
               checkOutput("rsp_addr", 64'(bus.rsp_addr), 64'(e.addr));
               checkOutput("rsp_err", 64'(bus.rsp_err), 64'(e.err));
            end else if (cycle_cnt >= firstDue) begin
               checkOutput("rsp_valid overdue", 64'(bus.rsp_valid), 64'd1);
            end
         end else begin
            checkOutput("rsp_valid held", 64'(bus.rsp_valid), 64'd1);
            checkOutput("rsp_addr held", 64'(bus.rsp_addr), 64'(e.addr));
            checkOutput("rsp_op held", 64'(bus.rsp_op), 64'(e.op));
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            void'(sb.pop_front());
            headSeen   = 1'b0;
            lastPopCnt = cycle_cnt;
         end
      end
   end

   initial begin
      // Single miss
      doReset();
      bus.rsp_ready = 1'b1;
      applyStimulus(2'd0, 33'h000001000, 5, 105);
      waitDrain();

      // Same-row pair: the hit is pushed behind the older miss
      doReset();
      bus.rsp_ready = 1'b1;
      applyStimulus(2'd0, 33'h000002000, 10, 110);
      applyStimulus(2'd0, 33'h000002040, 11, 111);
      waitDrain();

      // Illegal op completes like a read with the error flag
      doReset();
      bus.rsp_ready = 1'b1;
      applyStimulus(2'd3, 33'h000003000, 0, 100);
      waitDrain();

      // Fill all 16 slots, then a refused 17th offer, then one pop frees a slot
      doReset();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(2'd2, 33'h000004000 + 33'(i * 4), longint'(i + 1), longint'(101 + i));
      end
      checkOutput("req_ready when full", 64'(bus.req_ready), 64'd0);
      bus.req_valid = 1'b1;
      bus.req_op    = 2'd0;
      bus.req_addr  = 33'h000012000;
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      checkOutput("req_ready still full", 64'(bus.req_ready), 64'd0);
      bus.req_valid = 1'b0;
      waitValid();
      bus.rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      bus.rsp_ready = 1'b0;
      checkOutput("req_ready after one pop", 64'(bus.req_ready), 64'd1);
      bus.rsp_ready = 1'b1;
      waitDrain();
      repeat (40) @(posedge clock);
      #1;

      // Backpressure: head held for 20 cycles, younger entry must wait behind it
      doReset();
      applyStimulus(2'd1, 33'h100000000, 3, 103);
      applyStimulus(2'd0, 33'h000020000, 4, 104);
      waitValid();
      repeat (20) begin
         @(posedge clock);
         #1;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      bus.rsp_ready = 1'b0;
      checkOutput("one entry left after single pop", 64'(sb.size()), 64'd1);
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      bus.rsp_ready = 1'b1;
      waitDrain();

      // Reset with three pending entries: nothing completes and the old row is forgotten
      doReset();
      bus.rsp_ready = 1'b1;
      applyStimulus(2'd0, 33'h000006000, 1, 101);
      applyStimulus(2'd0, 33'h000008000, 2, 102);
      applyStimulus(2'd0, 33'h00000A000, 3, 103);
      waitCnt(50);
      doReset();
      bus.rsp_ready = 1'b1;
      applyStimulus(2'd0, 33'h00000A000, 120, 220);
      waitDrain();

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global timeout: got no end of test, expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end
endmodule
